// File: rtl/clock_time_core_if.sv
// Command/display bundle between the clock mode FSM (master) and clock_time_core (slave).
interface clock_time_core_if;
  logic       sec_tick;
  logic       en;
  logic       updown;
  logic       inc_hour;
  logic       inc_min;
  logic       alm_inc_hour;
  logic       alm_inc_min;
  logic       disp_sel;
  logic       alarm_match;
  logic [6:0] seg;
  logic [3:0] an;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;

  modport master (
    output sec_tick, en, updown, inc_hour, inc_min, alm_inc_hour, alm_inc_min, disp_sel,
    input  alarm_match, seg, an, cur_hour, cur_min
  );

  modport slave (
    input  sec_tick, en, updown, inc_hour, inc_min, alm_inc_hour, alm_inc_min, disp_sel,
    output alarm_match, seg, an, cur_hour, cur_min
  );
endinterface

// File: rtl/clock_time_core.sv
// HH:MM:SS timekeeping, alarm compare and 4-digit multiplexed 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module clock_time_core #(
  parameter int unsigned SEC_PER_MIN = 60,
  parameter int unsigned SCAN_DIV    = 1
) (
  input  logic               clk_out,
  input  logic               reset,
  clock_time_core_if.slave   bus
);

  localparam int unsigned DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [5:0]  SEC_LAST = 6'(SEC_PER_MIN - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    alm_min_q, alm_min_d;
  logic [4:0]    alm_hour_q, alm_hour_d;
  logic          alarm_match_q, alarm_match_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic [4:0]    src_hour;
  logic [5:0]    src_min;
  logic [3:0]    digit;

  function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] step_min(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    sec_d         = sec_q;
    min_d         = min_q;
    hour_d        = hour_q;
    alm_min_d     = alm_min_q;
    alm_hour_d    = alm_hour_q;
    alarm_match_d = 1'b0;
    if (bus.en) begin
      if (bus.sec_tick) begin
        if (sec_q == SEC_LAST) begin
          sec_d = '0;
          min_d = step_min(min_q, 1'b1);
          if (min_q == 6'd59) hour_d = step_hour(hour_q, 1'b1);
          // Match only on a seconds-driven minute rollover, never on edits.
          alarm_match_d = (hour_d == alm_hour_q) && (min_d == alm_min_q);
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end else begin
      if (bus.inc_hour)     hour_d     = step_hour(hour_q, bus.updown);
      if (bus.inc_min) begin
        min_d = step_min(min_q, bus.updown);
        sec_d = '0;
      end
      if (bus.alm_inc_hour) alm_hour_d = step_hour(alm_hour_q, bus.updown);
      if (bus.alm_inc_min)  alm_min_d  = step_min(alm_min_q, bus.updown);
    end
  end

  // seg/an are computed from the index being entered so digit and anode switch together.
  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
    src_hour = bus.disp_sel ? alm_hour_q : hour_q;
    src_min  = bus.disp_sel ? alm_min_q  : min_q;
    case (idx_d)
      2'd0:    digit = 4'(src_min % 6'd10);
      2'd1:    digit = 4'(src_min / 6'd10);
      2'd2:    digit = 4'(src_hour % 5'd10);
      default: digit = 4'(src_hour / 5'd10);
    endcase
    an_d  = ~(4'b0001 << idx_d);
    seg_d = seg7(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_d == 2'd3 && digit == 4'd0) seg_d = '1;
`endif
  end

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      sec_q         <= '0;
      min_q         <= '0;
      hour_q        <= '0;
      alm_min_q     <= '0;
      alm_hour_q    <= '0;
      alarm_match_q <= 1'b0;
      div_q         <= '0;
      idx_q         <= '0;
      seg_q         <= 7'b1000000;
      an_q          <= 4'b1110;
    end else begin
      sec_q         <= sec_d;
      min_q         <= min_d;
      hour_q        <= hour_d;
      alm_min_q     <= alm_min_d;
      alm_hour_q    <= alm_hour_d;
      alarm_match_q <= alarm_match_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign bus.alarm_match = alarm_match_q;
  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.cur_hour    = hour_q;
  assign bus.cur_min     = min_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Directed vector bench for clock_time_core with SEC_PER_MIN=4, SCAN_DIV=1.
module tb_clock_time_core;

  logic clk_out = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  clock_time_core_if bus ();

  clock_time_core #(.SEC_PER_MIN(4), .SCAN_DIV(1)) dut (
    .clk_out (clk_out),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_out = ~clk_out;

  typedef struct {
    logic       en, ud, ih, im, aih, aim, tick;
    logic [4:0] h;
    logic [5:0] m;
    logic       match;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, ud, ih, im, aih, aim, tick,
                     input logic [4:0] h, input logic [5:0] m, input logic match);
    vec_t v;
    v.en = en; v.ud = ud; v.ih = ih; v.im = im; v.aih = aih; v.aim = aim; v.tick = tick;
    v.h = h; v.m = m; v.match = match;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, ud, ih, im, aih, aim, tick);
    bus.en = en; bus.updown = ud; bus.inc_hour = ih; bus.inc_min = im;
    bus.alm_inc_hour = aih; bus.alm_inc_min = aim; bus.sec_tick = tick;
  endtask

  task automatic pulse(input logic ud, ih, im);
    drive(1'b0, ud, ih, im, 1'b0, 1'b0, 1'b0);
    @(negedge clk_out);
    drive(1'b0, ud, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [3:0] an_order [4];
  logic [6:0] seg_1234 [4];
  logic [6:0] seg_alm;
  int k;

  initial begin
    an_order = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_1234 = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    bus.disp_sel = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //    en ud ih im aih aim tk   h   m  match
    add(1, 0, 0, 0, 0, 0, 1,  0,  0, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  0, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  0, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  1, 0);
    add(1, 1, 1, 0, 0, 0, 0,  0,  1, 0);
    add(1, 1, 0, 1, 0, 1, 0,  0,  1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 23,  1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 23,  0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 23, 59, 0);
    add(0, 0, 0, 0, 0, 0, 1, 23, 59, 0);
    add(1, 0, 0, 0, 0, 0, 1, 23, 59, 0);
    add(1, 0, 0, 0, 0, 0, 1, 23, 59, 0);
    add(1, 0, 0, 0, 0, 0, 1, 23, 59, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  0, 1);
    add(1, 0, 0, 0, 0, 0, 0,  0,  0, 0);
    add(0, 1, 0, 0, 0, 1, 0,  0,  0, 0);
    add(0, 1, 0, 0, 0, 1, 0,  0,  0, 0);
    add(0, 1, 0, 1, 0, 0, 0,  0,  1, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  1, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  1, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  1, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  2, 1);
    add(1, 0, 0, 0, 0, 0, 0,  0,  2, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  2, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  2, 0);
    add(0, 1, 0, 1, 0, 0, 0,  0,  3, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  3, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  3, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  3, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0,  4, 0);
    add(0, 1, 1, 1, 1, 1, 0,  1,  5, 0);
    add(0, 0, 0, 1, 0, 0, 0,  1,  4, 0);
    add(0, 0, 0, 1, 0, 0, 0,  1,  3, 0);

    // Reset state
    @(negedge clk_out);
    check("rst_an",    32'(bus.an), 32'(4'b1110));
    check("rst_seg",   32'(bus.seg), 32'(7'b1000000));
    check("rst_hour",  32'(bus.cur_hour), 0);
    check("rst_min",   32'(bus.cur_min), 0);
    check("rst_match", 32'(bus.alarm_match), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].ud, vecs[i].ih, vecs[i].im, vecs[i].aih, vecs[i].aim, vecs[i].tick);
      @(negedge clk_out);
      check($sformatf("v%0d_hour", i),  32'(bus.cur_hour), 32'(vecs[i].h));
      check($sformatf("v%0d_min", i),   32'(bus.cur_min), 32'(vecs[i].m));
      check($sformatf("v%0d_match", i), 32'(bus.alarm_match), 32'(vecs[i].match));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Display scan of 12:34 and of alarm 00:00
    reset = 1'b1;
    @(negedge clk_out);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) pulse(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 34; i++) pulse(1'b1, 1'b0, 1'b1);
    @(negedge clk_out);
    check("preload_hour", 32'(bus.cur_hour), 12);
    check("preload_min",  32'(bus.cur_min), 34);
    k = 0;
    for (int j = 0; j < 4; j++) if (bus.an == an_order[j]) k = j;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("scan%0d_an", i),  32'(bus.an), 32'(an_order[k]));
      check($sformatf("scan%0d_seg", i), 32'(bus.seg), 32'(seg_1234[k]));
      k = (k + 1) % 4;
      @(negedge clk_out);
    end
    bus.disp_sel = 1'b1;
    @(negedge clk_out);
    @(negedge clk_out);
    for (int i = 0; i < 4; i++) begin
      seg_alm = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
      if (bus.an == 4'b0111) seg_alm = 7'b1111111;
`endif
      check($sformatf("alm_disp%0d_seg", i), 32'(bus.seg), 32'(seg_alm));
      @(negedge clk_out);
    end
    bus.disp_sel = 1'b0;

    // Mid-count asynchronous reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (6) @(negedge clk_out);
    check("pre_rst_min", 32'(bus.cur_min), 35);
    @(posedge clk_out);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_hour", 32'(bus.cur_hour), 0);
    check("mid_rst_min",  32'(bus.cur_min), 0);
    check("mid_rst_an",   32'(bus.an), 32'(4'b1110));
    check("mid_rst_seg",  32'(bus.seg), 32'(7'b1000000));
    check("mid_rst_match", 32'(bus.alarm_match), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_out);
    reset = 1'b0;
    @(negedge clk_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
